// File: rtl/vector_issue_unit_pkg.sv
// Shared vector defines: lane width and opcode encodings used by the issue unit, its ALU and bench.
package vector_issue_unit_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_VADD = 3'b000;
    localparam logic [OP_W-1:0] OP_VSUB = 3'b001;
    localparam logic [OP_W-1:0] OP_VAND = 3'b010;
    localparam logic [OP_W-1:0] OP_VOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_VXOR = 3'b100;

endpackage

// File: rtl/vector_lane_alu.sv
// Combinational lane-wise vector ALU; lanes are independent, nothing crosses a lane boundary.
// Optional feature: define VECTOR_SATURATION_EN for unsigned saturating VADD/VSUB.
module vector_lane_alu
    import vector_issue_unit_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic [OP_W-1:0]         op,
    input  logic [LANES*LANE_W-1:0] a,
    input  logic [LANES*LANE_W-1:0] b,
    output logic [LANES*LANE_W-1:0] result_c,
    output logic                    illegal_c
);

    // Codes above VXOR are undefined.
    assign illegal_c = (op > OP_VXOR);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] la;
        logic [LANE_W-1:0] lb;
        logic [LANE_W-1:0] add;
        logic [LANE_W-1:0] sub;
        logic [LANE_W-1:0] res;

        assign la = a[i*LANE_W +: LANE_W];
        assign lb = b[i*LANE_W +: LANE_W];

`ifdef VECTOR_SATURATION_EN
        logic [LANE_W:0] sum;
        logic [LANE_W:0] diff;

        // Ninth bit flags carry-out on add and borrow on subtract.
        assign sum  = {1'b0, la} + {1'b0, lb};
        assign diff = {1'b0, la} - {1'b0, lb};
        assign add  = sum[LANE_W]  ? {LANE_W{1'b1}} : sum[LANE_W-1:0];
        assign sub  = diff[LANE_W] ? {LANE_W{1'b0}} : diff[LANE_W-1:0];
`else
        // Modulo-256 lane arithmetic.
        assign add = la + lb;
        assign sub = la - lb;
`endif

        // Per-lane opcode select; undefined codes give zero.
        always_comb begin
            res = '0;
            case (op)
                OP_VADD: res = add;
                OP_VSUB: res = sub;
                OP_VAND: res = la & lb;
                OP_VOR:  res = la | lb;
                OP_VXOR: res = la ^ lb;
                default: res = '0;
            endcase
        end

        assign result_c[i*LANE_W +: LANE_W] = res;
    end

endmodule

// File: rtl/vector_issue_unit.sv
// Vector issue unit: request FIFO feeding one lane-wise ALU and a registered, back-pressured result.
// Optional feature: VECTOR_SATURATION_EN (saturating VADD/VSUB inside vector_lane_alu).
module vector_issue_unit
    import vector_issue_unit_pkg::*;
#(
    parameter int unsigned LANES      = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         vector_unit_control,
    input  logic [LANES*LANE_W-1:0] vector_input_1,
    input  logic [LANES*LANE_W-1:0] vector_input_2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] vector_result,
    output logic                    illegal_op,
    output logic                    busy,
    output logic [15:0]             op_count
);

    localparam int unsigned DATA_W = LANES * LANE_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    req_t              mem [FIFO_DEPTH];
    req_t              head_req;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic              push;
    logic              pop;
    logic              free;
    logic              out_valid_n;
    logic [DATA_W-1:0] alu_result_c;
    logic              alu_illegal_c;
    state_t            state;

    // Handshake decode from registered occupancy and output state only.
    assign in_ready    = (count < CNT_W'(FIFO_DEPTH));
    assign push        = in_valid && in_ready;
    assign free        = !out_valid || out_ready;
    assign pop         = free && (count != '0);
    assign out_valid_n = pop || (out_valid && !free);
    assign head_req    = mem[head];
    assign busy        = (state != IDLE);

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
    end

    vector_lane_alu #(.LANES(LANES)) u_alu (
        .op        (head_req.op),
        .a         (head_req.a),
        .b         (head_req.b),
        .result_c  (alu_result_c),
        .illegal_c (alu_illegal_c)
    );

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{op: vector_unit_control, a: vector_input_1, b: vector_input_2};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count_n;
        end
    end

    // Result register: load on pop, hold while stalled, clear when drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            vector_result <= '0;
            illegal_op    <= 1'b0;
            op_count      <= '0;
        end else begin
            out_valid <= out_valid_n;
            if (pop) begin
                vector_result <= alu_result_c;
                illegal_op    <= alu_illegal_c;
            end
            if (out_valid && out_ready) op_count <= op_count + 16'd1;
        end
    end

    // Control FSM tracking idle, issuing and back-pressured phases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (push) state <= RUN;
                RUN: begin
                    if (out_valid && !out_ready)            state <= STALL;
                    else if (count_n == '0 && !out_valid_n) state <= IDLE;
                end
                STALL: begin
                    if (out_ready) state <= (count_n == '0 && !out_valid_n) ? IDLE : RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_issue_unit.sv
// Directed self-checking bench for vector_issue_unit (default LANES=4, FIFO_DEPTH=2).
// Honours VECTOR_SATURATION_EN for the expected saturating results.
module tb_vector_issue_unit;
    import vector_issue_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  vector_unit_control;
    logic [31:0] vector_input_1;
    logic [31:0] vector_input_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] vector_result;
    logic        illegal_op;
    logic        busy;
    logic [15:0] op_count;

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] exp_ops = 16'd0;

    vector_issue_unit #(.LANES(4), .FIFO_DEPTH(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .vector_unit_control (vector_unit_control),
        .vector_input_1      (vector_input_1),
        .vector_input_2      (vector_input_2),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .vector_result       (vector_result),
        .illegal_op          (illegal_op),
        .busy                (busy),
        .op_count            (op_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge (caller ensures in_ready).
    task automatic push_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid            = 1'b1;
        vector_unit_control = op;
        vector_input_1      = a;
        vector_input_2      = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vector_unit_control = 3'b000;
        vector_input_1 = '0;
        vector_input_2 = '0;
        tick();
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (op_count !== 16'd0) begin miscompares++; $display("FAIL rst_op_count: got %0d want 0", op_count); end
        vectors++; if (vector_result !== 32'h0) begin miscompares++; $display("FAIL rst_result: got %h want 0", vector_result); end
        vectors++; if (illegal_op !== 1'b0) begin miscompares++; $display("FAIL rst_illegal: got %b want 0", illegal_op); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_vadd_latency();
        out_ready = 1'b1;
        push_req(OP_VADD, 32'h0F0F0F0F, 32'h60606060);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_k_valid: got %b want 0", out_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL lat_k_busy: got %b want 1", busy); end
        tick();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL lat_k1_valid: got %b want 1", out_valid); end
        vectors++; if (vector_result !== 32'h6F6F6F6F) begin miscompares++; $display("FAIL lat_result: got %h want 6f6f6f6f", vector_result); end
        tick();
        exp_ops++;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_drain_valid: got %b want 0", out_valid); end
        vectors++; if (op_count !== exp_ops) begin miscompares++; $display("FAIL lat_op_count: got %0d want %0d", op_count, exp_ops); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL lat_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_lanewise();
        logic [2:0]  ops  [5];
        logic [31:0] as   [5];
        logic [31:0] bs   [5];
        logic [31:0] exps [5];
        ops[0] = OP_VSUB; as[0] = 32'hFFFFFFFF; bs[0] = 32'hF0F0F0F0; exps[0] = 32'h0F0F0F0F;
        ops[1] = OP_VADD; as[1] = 32'hFF01FF01; bs[1] = 32'h01010101;
        ops[2] = OP_VSUB; as[2] = 32'h00100510; bs[2] = 32'h01010101;
`ifdef VECTOR_SATURATION_EN
        exps[1] = 32'hFF02FF02;
        exps[2] = 32'h000F040F;
`else
        exps[1] = 32'h00020002;
        exps[2] = 32'hFF0F040F;
`endif
        ops[3] = OP_VAND; as[3] = 32'hF0F0F0F0; bs[3] = 32'h3C3C3C3C; exps[3] = 32'h30303030;
        ops[4] = OP_VOR;  as[4] = 32'h0F00F000; bs[4] = 32'h00F00F00; exps[4] = 32'h0FF0FF00;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_req(ops[i], as[i], bs[i]);
            tick();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL lane%0d_valid: got %b want 1", i, out_valid); end
            vectors++; if (vector_result !== exps[i]) begin miscompares++; $display("FAIL lane%0d_result: got %h want %h", i, vector_result, exps[i]); end
            vectors++; if (illegal_op !== 1'b0) begin miscompares++; $display("FAIL lane%0d_illegal: got %b want 0", i, illegal_op); end
            tick();
            exp_ops++;
        end
        vectors++; if (op_count !== exp_ops) begin miscompares++; $display("FAIL lane_op_count: got %0d want %0d", op_count, exp_ops); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        push_req(3'b110, 32'h12345678, 32'h9ABCDEF0);
        push_req(OP_VXOR, 32'hAAAAAAAA, 32'hFFFFFFFF);
        vectors++; if (vector_result !== 32'h0) begin miscompares++; $display("FAIL ill_result: got %h want 0", vector_result); end
        vectors++; if (illegal_op !== 1'b1) begin miscompares++; $display("FAIL ill_flag: got %b want 1", illegal_op); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ill_valid: got %b want 1", out_valid); end
        tick();
        exp_ops++;
        vectors++; if (vector_result !== 32'h55555555) begin miscompares++; $display("FAIL xor_result: got %h want 55555555", vector_result); end
        vectors++; if (illegal_op !== 1'b0) begin miscompares++; $display("FAIL xor_illegal: got %b want 0", illegal_op); end
        tick();
        exp_ops++;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ill_drain_valid: got %b want 0", out_valid); end
        vectors++; if (op_count !== exp_ops) begin miscompares++; $display("FAIL ill_op_count: got %0d want %0d", op_count, exp_ops); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        push_req(OP_VADD, 32'h01010101, 32'h01010101);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
        push_req(OP_VOR, 32'h10203040, 32'h01020304);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready2: got %b want 1", in_ready); end
        push_req(OP_VXOR, 32'hFFFF0000, 32'h0F0F0F0F);
        for (int s = 0; s < 3; s++) begin
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full%0d: got %b want 0", s, in_ready); end
            vectors++; if (vector_result !== 32'h02020202 || out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_hold1_%0d: got %h/%b want 02020202/1", s, vector_result, out_valid); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy%0d: got %b want 1", s, busy); end
            if (s < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        exp_ops++;
        vectors++; if (vector_result !== 32'h11223344) begin miscompares++; $display("FAIL b2b_res2: got %h want 11223344", vector_result); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after: got %b want 1", in_ready); end
        out_ready = 1'b0;
        tick();
        vectors++; if (vector_result !== 32'h11223344 || out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_hold2: got %h/%b want 11223344/1", vector_result, out_valid); end
        out_ready = 1'b1;
        tick();
        exp_ops++;
        vectors++; if (vector_result !== 32'hF0F00F0F) begin miscompares++; $display("FAIL b2b_res3: got %h want f0f00f0f", vector_result); end
        tick();
        exp_ops++;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
        vectors++; if (op_count !== exp_ops) begin miscompares++; $display("FAIL b2b_op_count: got %0d want %0d", op_count, exp_ops); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_in_stall();
        out_ready = 1'b0;
        push_req(OP_VADD, 32'h11111111, 32'h22222222);
        push_req(OP_VADD, 32'h33333333, 32'h11111111);
        push_req(OP_VADD, 32'h44444444, 32'h11111111);
        vectors++; if (busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL rs_pre: got busy %b ready %b want 1/0", busy, in_ready); end
        reset = 1'b1;
        #1;
        exp_ops = 16'd0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rs_valid: got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rs_ready: got %b want 1", in_ready); end
        vectors++; if (op_count !== 16'd0) begin miscompares++; $display("FAIL rs_op_count: got %0d want 0", op_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rs_busy: got %b want 0", busy); end
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rs_stale%0d: got %b want 0", c, out_valid); end
        end
        push_req(OP_VAND, 32'hFFFF0000, 32'h12345678);
        tick();
        vectors++; if (vector_result !== 32'h12340000 || out_valid !== 1'b1) begin miscompares++; $display("FAIL rs_fresh: got %h/%b want 12340000/1", vector_result, out_valid); end
        tick();
        exp_ops++;
        vectors++; if (op_count !== exp_ops) begin miscompares++; $display("FAIL rs_op_count_after: got %0d want %0d", op_count, exp_ops); end
    endtask

    initial begin
        test_reset();
        test_vadd_latency();
        test_lanewise();
        test_illegal();
        test_back_to_back();
        test_reset_in_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
